// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer with run/halt control, stall hold, redirect flush
// and a saturating retired-instruction counter.
// Optional return stack enabled by defining PC_CALLSTACK_EN; without it call_in
// acts as a jump, ret_in is ignored and err_out is tied low.
module pc_seq_ctrl #(
    parameter int PC_W    = 16,
    parameter int OFF_W   = 8,
    parameter int STACK_D = 4
) (
    input  logic             CLK,
    input  logic             reset_ctrl_n,
    input  logic             start_in,
    input  logic             stall_in,
    input  logic             halt_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             branch_in,
    input  logic [OFF_W-1:0] branch_off_in,
    input  logic             jump_in,
    input  logic [PC_W-1:0]  target_in,
    input  logic             call_in,
    input  logic             ret_in,
    output logic [PC_W-1:0]  pcnext_out,
    output logic             pc_reset_out,
    output logic             flush_out,
    output logic             done_out,
    output logic             err_out,
    output logic [15:0]      icount_out
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

    state_t      state_q, state_d;
    logic        flush_q, flush_d;
    logic [15:0] icount_q, icount_d;
    logic        count_en;

    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;

    assign pc_inc = pc_in + PC_W'(1);
    assign pc_br  = pc_in + {{(PC_W-OFF_W){branch_off_in[OFF_W-1]}}, branch_off_in};

`ifdef PC_CALLSTACK_EN
    localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
    localparam int SP_W  = $clog2(STACK_D + 1);

    logic [PC_W-1:0]  stk_q [STACK_D];
    logic [SP_W-1:0]  sp_q;
    logic             push, pop, err_set, err_q;
    logic [IDX_W-1:0] top_idx;

    assign top_idx = IDX_W'(sp_q - 1'b1);
    assign err_out = err_q;

    // Return stack: push on call (oldest entry dropped when full), pop on ret
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            sp_q <= '0;
            for (int i = 0; i < STACK_D; i++) stk_q[i] <= '0;
        end else if (push) begin
            if (sp_q == SP_W'(STACK_D)) begin
                for (int i = 0; i < STACK_D-1; i++) stk_q[i] <= stk_q[i+1];
                stk_q[STACK_D-1] <= pc_inc;
            end else begin
                stk_q[IDX_W'(sp_q)] <= pc_inc;
                sp_q <= sp_q + 1'b1;
            end
        end else if (pop) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) err_q <= 1'b0;
        else               err_q <= err_q | err_set;
    end
`else
    logic unused_ret;
    localparam int unused_stack_d = STACK_D;
    assign unused_ret = ret_in;
    assign err_out    = 1'b0;
`endif

    // Next state, next PC and event decode; reset forces the IDLE outputs immediately
    always_comb begin
        state_d      = state_q;
        pcnext_out   = pc_in;
        pc_reset_out = 1'b0;
        done_out     = 1'b0;
        flush_d      = 1'b0;
        count_en     = 1'b0;
`ifdef PC_CALLSTACK_EN
        push         = 1'b0;
        pop          = 1'b0;
        err_set      = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                pc_reset_out = 1'b1;
                pcnext_out   = '0;
                if (start_in) state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall_in) begin
                    count_en = 1'b1;
                    if (halt_in) begin
                        state_d = S_HALT;
`ifdef PC_CALLSTACK_EN
                    end else if (ret_in) begin
                        if (sp_q == '0) begin
                            err_set = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            pop        = 1'b1;
                            pcnext_out = stk_q[top_idx];
                            flush_d    = 1'b1;
                        end
                    end else if (call_in) begin
                        push       = 1'b1;
                        pcnext_out = target_in;
                        flush_d    = 1'b1;
`else
                    end else if (call_in) begin
                        pcnext_out = target_in;
                        flush_d    = 1'b1;
`endif
                    end else if (jump_in) begin
                        pcnext_out = target_in;
                        flush_d    = 1'b1;
                    end else if (branch_in) begin
                        pcnext_out = pc_br;
                        flush_d    = 1'b1;
                    end else begin
                        pcnext_out = pc_inc;
                    end
                end
            end
            S_HALT: begin
                done_out = 1'b1;
                if (start_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        icount_d = icount_q;
        if (count_en && icount_q != 16'hFFFF) icount_d = icount_q + 16'd1;
        if (!reset_ctrl_n) begin
            pcnext_out   = '0;
            pc_reset_out = 1'b1;
            done_out     = 1'b0;
        end
    end

    // State, flush pulse and retired-instruction counter registers
    always_ff @(posedge CLK or negedge reset_ctrl_n) begin
        if (!reset_ctrl_n) begin
            state_q  <= S_IDLE;
            flush_q  <= 1'b0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            flush_q  <= flush_d;
            icount_q <= icount_d;
        end
    end

    assign flush_out  = flush_q;
    assign icount_out = icount_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed testbench for pc_seq_ctrl; return-stack checks run when PC_CALLSTACK_EN is defined.
module tb_pc_seq_ctrl;

    logic        CLK = 1'b0;
    logic        reset_ctrl_n, start_in, stall_in, halt_in, branch_in, jump_in, call_in, ret_in;
    logic [15:0] pc_in, target_in;
    logic [7:0]  branch_off_in;
    logic [15:0] pcnext_out, icount_out;
    logic        pc_reset_out, flush_out, done_out, err_out;

    int errs   = 0;
    int checks = 0;

    pc_seq_ctrl #(.PC_W(16), .OFF_W(8), .STACK_D(4)) dut (
        .CLK(CLK), .reset_ctrl_n(reset_ctrl_n), .start_in(start_in), .stall_in(stall_in),
        .halt_in(halt_in), .pc_in(pc_in), .branch_in(branch_in), .branch_off_in(branch_off_in),
        .jump_in(jump_in), .target_in(target_in), .call_in(call_in), .ret_in(ret_in),
        .pcnext_out(pcnext_out), .pc_reset_out(pc_reset_out), .flush_out(flush_out),
        .done_out(done_out), .err_out(err_out), .icount_out(icount_out)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock edge and sample 1 time unit later
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_ctrl();
        start_in = 0; stall_in = 0; halt_in = 0; branch_in = 0;
        jump_in = 0; call_in = 0; ret_in = 0;
    endtask

    // async reset pulse between edges, then start into RUN with pc_in=0
    task automatic reset_and_start();
        reset_ctrl_n = 0;
        #1;
        reset_ctrl_n = 1;
        clr_ctrl();
        start_in = 1;
        step();
        start_in = 0;
        pc_in    = 16'h0000;
    endtask

    initial begin
        reset_ctrl_n = 0; clr_ctrl();
        pc_in = 16'h0042; target_in = 16'h0000; branch_off_in = 8'h00;
        #3;
        chk("rst_pcnext", pcnext_out, 16'h0000);
        chk("rst_pcreset", pc_reset_out, 1'b1);
        chk("rst_done", done_out, 1'b0);
        chk("rst_flush", flush_out, 1'b0);
        chk("rst_err", err_out, 1'b0);
        chk("rst_icount", icount_out, 16'h0000);
        #4 reset_ctrl_n = 1;
        #1;
        chk("idle_pcnext", pcnext_out, 16'h0000);
        chk("idle_pcreset", pc_reset_out, 1'b1);

        // IDLE -> RUN
        start_in = 1;
        step();
        start_in = 0; pc_in = 16'h0000;
        #1;
        chk("run_first_pcnext", pcnext_out, 16'h0001);
        chk("run_pcreset", pc_reset_out, 1'b0);
        chk("run_icount0", icount_out, 16'h0000);
        step();
        pc_in = 16'h0010;
        #1;
        chk("inc_0010", pcnext_out, 16'h0011);
        chk("icount1", icount_out, 16'h0001);
        step();
        pc_in = 16'hFFFF;
        #1;
        chk("wrap_ffff", pcnext_out, 16'h0000);
        step();
        chk("icount3", icount_out, 16'h0003);

        // taken branch, negative offset
        branch_in = 1; branch_off_in = 8'hFE; pc_in = 16'h0010;
        #1;
        chk("br_pcnext", pcnext_out, 16'h000E);
        chk("br_flush_before", flush_out, 1'b0);
        step();
        chk("br_flush_after", flush_out, 1'b1);
        branch_in = 0; pc_in = 16'h000E;
        #1;
        chk("post_br_pcnext", pcnext_out, 16'h000F);
        step();
        chk("flush_cleared", flush_out, 1'b0);
        chk("icount5", icount_out, 16'h0005);

        // branch offset wraps below zero
        branch_in = 1; branch_off_in = 8'hFE; pc_in = 16'h0001;
        #1;
        chk("br_wrap", pcnext_out, 16'hFFFF);
        step();
        // stalled branch: hold, no flush, no count
        stall_in = 1; branch_in = 1; pc_in = 16'h0010;
        #1;
        chk("stall_pcnext", pcnext_out, 16'h0010);
        step();
        chk("stall_flush", flush_out, 1'b0);
        chk("stall_icount", icount_out, 16'h0006);
        stall_in = 0;

        // jump beats branch
        jump_in = 1; branch_in = 1; target_in = 16'h0200; pc_in = 16'h0010;
        #1;
        chk("jump_pcnext", pcnext_out, 16'h0200);
        step();
        chk("jump_flush", flush_out, 1'b1);
        chk("icount7", icount_out, 16'h0007);
        clr_ctrl();

        // async reset mid-RUN
        pc_in = 16'h0042;
        reset_ctrl_n = 0;
        #1;
        chk("midrst_pcnext", pcnext_out, 16'h0000);
        chk("midrst_pcreset", pc_reset_out, 1'b1);
        chk("midrst_icount", icount_out, 16'h0000);
        chk("midrst_flush", flush_out, 1'b0);
        reset_ctrl_n = 1;
        #1;
        chk("midrst_idle", pc_reset_out, 1'b1);
        start_in = 1;
        step();
        start_in = 0; pc_in = 16'h0000;
        #1;
        chk("restart_pcnext", pcnext_out, 16'h0001);

        // halt with simultaneous start: HALT wins
        halt_in = 1; start_in = 1; pc_in = 16'h0030;
        #1;
        chk("halt_pcnext", pcnext_out, 16'h0030);
        chk("halt_done_before", done_out, 1'b0);
        step();
        clr_ctrl();
        branch_in = 1; jump_in = 1; target_in = 16'h0200; pc_in = 16'h0055;
        #1;
        chk("halt_done", done_out, 1'b1);
        chk("halt_tracks_pc", pcnext_out, 16'h0055);
        chk("halt_icount", icount_out, 16'h0001);
        step();
        chk("halt_no_flush", flush_out, 1'b0);
        chk("halt_hold_icount", icount_out, 16'h0001);
        clr_ctrl();
        start_in = 1;
        step();
        start_in = 0;
        #1;
        chk("halt_to_idle_rst", pc_reset_out, 1'b1);
        chk("halt_to_idle_done", done_out, 1'b0);

`ifdef PC_CALLSTACK_EN
        // call / ret round trip
        reset_and_start();
        call_in = 1; target_in = 16'h0100; pc_in = 16'h0020;
        #1;
        chk("call_pcnext", pcnext_out, 16'h0100);
        step();
        call_in = 0; ret_in = 1; pc_in = 16'h0105;
        #1;
        chk("ret_pcnext", pcnext_out, 16'h0021);
        step();
        chk("ret_flush", flush_out, 1'b1);
        ret_in = 0;
        // 5 nested calls into a 4-deep stack
        for (int k = 1; k <= 5; k++) begin
            call_in = 1; pc_in = 16'(k * 16); target_in = 16'h0300;
            step();
        end
        call_in = 0; ret_in = 1; pc_in = 16'h0400;
        #1; chk("ret1", pcnext_out, 16'h0051); step();
        #1; chk("ret2", pcnext_out, 16'h0041); step();
        #1; chk("ret3", pcnext_out, 16'h0031); step();
        #1; chk("ret4", pcnext_out, 16'h0021); step();
        #1;
        chk("ret5_hold", pcnext_out, 16'h0400);
        step();
        ret_in = 0;
        chk("underflow_err", err_out, 1'b1);
        chk("underflow_halt", done_out, 1'b1);
`else
        // without a stack, ret is ignored and the PC simply increments
        reset_and_start();
        ret_in = 1; pc_in = 16'h0020;
        #1;
        chk("ret_ignored", pcnext_out, 16'h0021);
        step();
        chk("ret_no_flush", flush_out, 1'b0);
        chk("ret_no_err", err_out, 1'b0);
        ret_in = 0;
        call_in = 1; target_in = 16'h0100; pc_in = 16'h0020;
        #1;
        chk("call_as_jump", pcnext_out, 16'h0100);
        step();
        chk("call_flush", flush_out, 1'b1);
        call_in = 0;
`endif

        // icount saturation
        reset_and_start();
        pc_in = 16'h0000;
        repeat (65534) @(posedge CLK);
        #1;
        chk("icount_fffe", icount_out, 16'hFFFE);
        step();
        chk("icount_ffff", icount_out, 16'hFFFF);
        step();
        chk("icount_sat1", icount_out, 16'hFFFF);
        step();
        chk("icount_sat2", icount_out, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
